// File: rtl/pkg_sudoku.sv
`default_nettype none
// ============================================================================
//  Module      : pkg_sudoku
//  Description : Shared Sudoku definitions: state codes (also decoded by the
//                hex-display block), digit width, "none" digit and the
//                one-hot switch to digit encoding rule.
//  Revision    : 1.0 - initial release
// ============================================================================
package pkg_sudoku;

    localparam int c_digito_w = 4;
    localparam logic [c_digito_w-1:0] c_nenhum = 4'd0;

    typedef enum logic [2:0] {
        S_LINHA    = 3'b000,
        S_COLUNA   = 3'b001,
        S_CONSULTA = 3'b010,
        S_VALOR    = 3'b011,
        S_ESCRITA  = 3'b100,
        S_ERRO     = 3'b101
    } estado_t;

    // Exactly one bit i set gives digit i+1; anything else gives "none".
    function automatic logic [c_digito_w-1:0] codifica_one_hot(input logic [8:0] sw);
        logic [c_digito_w-1:0] cod;
        int                    n;
        cod = c_nenhum;
        n   = 0;
        for (int i = 0; i < 9; i++) begin
            if (sw[i]) begin
                n   = n + 1;
                cod = 4'(i + 1);
            end
        end
        if (n != 1) begin
            cod = c_nenhum;
        end
        return cod;
    endfunction

endpackage
`default_nettype wire

// File: rtl/codificador_switch_sinc.sv
`default_nettype none
// ============================================================================
//  Module      : codificador_switch_sinc
//  Description : Registered one-hot switch to digit encoder; outputs 0 when
//                no bit or more than one bit is set. One cycle of latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module codificador_switch_sinc
    import pkg_sudoku::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8:0]            switch,
    output logic [c_digito_w-1:0] codigo
);

    logic [c_digito_w-1:0] r_codigo;

    // Register the encoded digit so it lines up with the registered button edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_codigo <= c_nenhum;
        end else begin
            r_codigo <= codifica_one_hot(switch);
        end
    end

    assign codigo = r_codigo;

endmodule
`default_nettype wire

// File: rtl/controle_entrada_jogada.sv
`default_nettype none
// ============================================================================
//  Module      : controle_entrada_jogada
//  Description : Sequences one Sudoku move: row, column, fixed-cell query,
//                value, board write. Detects button edges, encodes switches
//                and runs req/ack handshakes toward board storage.
//                Optional macro ENTRADA_TIMEOUT_EN adds an inactivity
//                timeout in S_COLUNA / S_VALOR.
//  Revision    : 1.0 - initial release
// ============================================================================
module controle_entrada_jogada
    import pkg_sudoku::*;
#(
    parameter int ERRO_CICLOS    = 50_000_000,
    parameter int TIMEOUT_CICLOS = 500_000_000
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] switch,
    input  logic       btn_confirma,
    input  logic       btn_cancela,
    input  logic       consulta_ok,
    input  logic       celula_fixa,
    input  logic       escrita_ack,
    output logic [3:0] regLinha,
    output logic [3:0] regColuna,
    output logic [3:0] regValor,
    output logic [2:0] estadoJogo,
    output logic       consulta_req,
    output logic       escrita_req,
    output logic       erro
);

    localparam int c_erro_w = (ERRO_CICLOS > 1) ? $clog2(ERRO_CICLOS) : 1;
    localparam logic [c_erro_w-1:0] c_erro_fim = c_erro_w'(ERRO_CICLOS - 1);

    estado_t               r_estado, w_estado_nxt;
    logic [c_digito_w-1:0] r_linha, r_coluna, r_valor;
    logic [c_digito_w-1:0] w_linha_nxt, w_coluna_nxt, w_valor_nxt;
    logic [c_digito_w-1:0] w_codigo;
    logic                  r_conf_ant, r_canc_ant, r_ev_conf, r_ev_canc;
    logic                  w_conf;
    logic                  r_erro_pulso, w_erro_inv;
    logic                  r_consulta_req, r_escrita_req;
    logic [c_erro_w-1:0]   r_cnt_erro;
    logic                  w_timeout;

    codificador_switch_sinc u_codificador (
        .clk    (clk),
        .reset  (reset),
        .switch (switch),
        .codigo (w_codigo)
    );

    // Registered rising-edge detection; history resets high so a held button gives no event.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_conf_ant <= 1'b1;
            r_canc_ant <= 1'b1;
            r_ev_conf  <= 1'b0;
            r_ev_canc  <= 1'b0;
        end else begin
            r_conf_ant <= btn_confirma;
            r_canc_ant <= btn_cancela;
            r_ev_conf  <= btn_confirma & ~r_conf_ant;
            r_ev_canc  <= btn_cancela  & ~r_canc_ant;
        end
    end

    // Cancel takes priority over a simultaneous confirm.
    assign w_conf = r_ev_conf & ~r_ev_canc;

`ifdef ENTRADA_TIMEOUT_EN
    localparam int c_inat_w = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [c_inat_w-1:0] c_inat_fim = c_inat_w'(TIMEOUT_CICLOS - 1);

    logic [8:0]          r_switch_ant;
    logic [c_inat_w-1:0] r_inat;
    logic                w_em_espera, w_limpa;

    assign w_em_espera = (r_estado == S_COLUNA) || (r_estado == S_VALOR);
    assign w_limpa     = r_ev_conf | r_ev_canc | (switch != r_switch_ant);
    assign w_timeout   = w_em_espera && !w_limpa && (r_inat == c_inat_fim);

    // Inactivity counter, restarted by any user activity or state change.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_switch_ant <= 9'd0;
            r_inat       <= '0;
        end else begin
            r_switch_ant <= switch;
            if (!w_em_espera || w_limpa || (w_estado_nxt != r_estado)) begin
                r_inat <= '0;
            end else begin
                r_inat <= r_inat + 1'b1;
            end
        end
    end
`else
    // Feature absent: never fires, entry waits indefinitely.
    assign w_timeout = (TIMEOUT_CICLOS < 0);
`endif

    // Next-state and next-register logic for the move sequence.
    always_comb begin
        w_estado_nxt = r_estado;
        w_linha_nxt  = r_linha;
        w_coluna_nxt = r_coluna;
        w_valor_nxt  = r_valor;
        w_erro_inv   = 1'b0;
        case (r_estado)
            S_LINHA: begin
                if (w_conf) begin
                    if (w_codigo == c_nenhum) begin
                        w_erro_inv = 1'b1;
                    end else begin
                        w_linha_nxt  = w_codigo;
                        w_estado_nxt = S_COLUNA;
                    end
                end
            end
            S_COLUNA: begin
                if (r_ev_canc) begin
                    w_coluna_nxt = c_nenhum;
                    w_estado_nxt = S_LINHA;
                end else if (w_conf) begin
                    if (w_codigo == c_nenhum) begin
                        w_erro_inv = 1'b1;
                    end else begin
                        w_coluna_nxt = w_codigo;
                        w_estado_nxt = S_CONSULTA;
                    end
                end
            end
            S_CONSULTA: begin
                if (consulta_ok) begin
                    w_estado_nxt = celula_fixa ? S_ERRO : S_VALOR;
                end
            end
            S_VALOR: begin
                if (r_ev_canc) begin
                    w_coluna_nxt = c_nenhum;
                    w_estado_nxt = S_COLUNA;
                end else if (w_conf) begin
                    if (w_codigo == c_nenhum) begin
                        w_erro_inv = 1'b1;
                    end else begin
                        w_valor_nxt  = w_codigo;
                        w_estado_nxt = S_ESCRITA;
                    end
                end
            end
            S_ESCRITA: begin
                if (escrita_ack) begin
                    w_linha_nxt  = c_nenhum;
                    w_coluna_nxt = c_nenhum;
                    w_valor_nxt  = c_nenhum;
                    w_estado_nxt = S_LINHA;
                end
            end
            S_ERRO: begin
                if (r_cnt_erro == c_erro_fim) begin
                    w_linha_nxt  = c_nenhum;
                    w_coluna_nxt = c_nenhum;
                    w_valor_nxt  = c_nenhum;
                    w_estado_nxt = S_LINHA;
                end
            end
            default: begin
                w_estado_nxt = S_LINHA;
            end
        endcase
        if (w_timeout) begin
            w_linha_nxt  = c_nenhum;
            w_coluna_nxt = c_nenhum;
            w_valor_nxt  = c_nenhum;
            w_estado_nxt = S_LINHA;
        end
    end

    // State, selection registers, error timer and registered request outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado       <= S_LINHA;
            r_linha        <= c_nenhum;
            r_coluna       <= c_nenhum;
            r_valor        <= c_nenhum;
            r_erro_pulso   <= 1'b0;
            r_consulta_req <= 1'b0;
            r_escrita_req  <= 1'b0;
            r_cnt_erro     <= '0;
        end else begin
            r_estado       <= w_estado_nxt;
            r_linha        <= w_linha_nxt;
            r_coluna       <= w_coluna_nxt;
            r_valor        <= w_valor_nxt;
            r_erro_pulso   <= w_erro_inv;
            r_consulta_req <= (w_estado_nxt == S_CONSULTA);
            r_escrita_req  <= (w_estado_nxt == S_ESCRITA);
            r_cnt_erro     <= (r_estado == S_ERRO) ? r_cnt_erro + 1'b1 : '0;
        end
    end

    assign regLinha     = r_linha;
    assign regColuna    = r_coluna;
    assign regValor     = r_valor;
    assign estadoJogo   = r_estado;
    assign consulta_req = r_consulta_req;
    assign escrita_req  = r_escrita_req;
    assign erro         = (r_estado == S_ERRO) | r_erro_pulso;

endmodule
`default_nettype wire

// File: tb/tb_controle_entrada_jogada.sv
`default_nettype none
// ============================================================================
//  Module      : tb_controle_entrada_jogada
//  Description : Directed stimulus for controle_entrada_jogada, checked each
//                cycle against a move-level model plus literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_entrada_jogada;

    localparam int ERRO = 4;
    localparam int TMO  = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] switch = 9'd0;
    logic       btn_confirma = 1'b0, btn_cancela = 1'b0;
    logic       consulta_ok = 1'b0, celula_fixa = 1'b0, escrita_ack = 1'b0;
    logic [3:0] regLinha, regColuna, regValor;
    logic [2:0] estadoJogo;
    logic       consulta_req, escrita_req, erro;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    controle_entrada_jogada #(
        .ERRO_CICLOS    (ERRO),
        .TIMEOUT_CICLOS (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .switch       (switch),
        .btn_confirma (btn_confirma),
        .btn_cancela  (btn_cancela),
        .consulta_ok  (consulta_ok),
        .celula_fixa  (celula_fixa),
        .escrita_ack  (escrita_ack),
        .regLinha     (regLinha),
        .regColuna    (regColuna),
        .regValor     (regValor),
        .estadoJogo   (estadoJogo),
        .consulta_req (consulta_req),
        .escrita_req  (escrita_req),
        .erro         (erro)
    );

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nome, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ model
    int         m_st, m_lin, m_col, m_val, m_left, m_idle, p_code;
    bit         m_pulse, m_valid, h_conf, h_canc, p_ec, p_ex;
    logic [8:0] m_sw_last;

    function automatic int digito(input logic [8:0] sw);
        if ($countones(sw) != 1) return 0;
        for (int i = 0; i < 9; i++) if (sw[i]) return i + 1;
        return 0;
    endfunction

    task automatic model_step();
        int ns;
        bit conf_v, ativo;
        if (reset) begin
            m_st = 0; m_lin = 0; m_col = 0; m_val = 0; m_left = 0; m_idle = 0;
            m_pulse = 0; h_conf = 1; h_canc = 1; p_ec = 0; p_ex = 0; p_code = 0;
            m_sw_last = 9'd0; m_valid = 1;
            return;
        end
        ns = m_st;
        m_pulse = 0;
        conf_v = p_ec && !p_ex;
        case (m_st)
            0: if (conf_v) begin
                   if (p_code == 0) m_pulse = 1; else begin m_lin = p_code; ns = 1; end
               end
            1: if (p_ex) begin m_col = 0; ns = 0; end
               else if (conf_v) begin
                   if (p_code == 0) m_pulse = 1; else begin m_col = p_code; ns = 2; end
               end
            2: if (consulta_ok) begin
                   ns = celula_fixa ? 5 : 3;
                   m_left = ERRO;
               end
            3: if (p_ex) begin m_col = 0; ns = 1; end
               else if (conf_v) begin
                   if (p_code == 0) m_pulse = 1; else begin m_val = p_code; ns = 4; end
               end
            4: if (escrita_ack) begin m_lin = 0; m_col = 0; m_val = 0; ns = 0; end
            5: begin
                   m_left--;
                   if (m_left == 0) begin m_lin = 0; m_col = 0; m_val = 0; ns = 0; end
               end
            default: ns = 0;
        endcase
`ifdef ENTRADA_TIMEOUT_EN
        ativo = (m_st == 1 || m_st == 3) && !p_ec && !p_ex && (switch == m_sw_last);
        if (ativo && m_idle == TMO - 1) begin
            m_lin = 0; m_col = 0; m_val = 0; ns = 0;
        end
        m_idle = (ativo && ns == m_st) ? m_idle + 1 : 0;
        m_sw_last = switch;
`else
        ativo = 0;
`endif
        m_st   = ns;
        p_ec   = btn_confirma && !h_conf;
        p_ex   = btn_cancela && !h_canc;
        h_conf = btn_confirma;
        h_canc = btn_cancela;
        p_code = digito(switch);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin
        model_step();
        #1;
        if (m_valid) begin
            chk("estadoJogo", estadoJogo, m_st);
            chk("regLinha", regLinha, m_lin);
            chk("regColuna", regColuna, m_col);
            chk("regValor", regValor, m_val);
            chk("consulta_req", consulta_req, (m_st == 2));
            chk("escrita_req", escrita_req, (m_st == 4));
            chk("erro", erro, (m_st == 5) || m_pulse);
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic ciclos(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic confirma(input logic [8:0] sw);
        @(negedge clk); switch = sw; btn_confirma = 1'b1;
        @(negedge clk); btn_confirma = 1'b0;
        ciclos(2);
    endtask

    task automatic cancela();
        @(negedge clk); btn_cancela = 1'b1;
        @(negedge clk); btn_cancela = 1'b0;
        ciclos(2);
    endtask

    task automatic pulso_ok(input logic fixa);
        @(negedge clk); consulta_ok = 1'b1; celula_fixa = fixa;
        @(negedge clk); consulta_ok = 1'b0; celula_fixa = 1'b0;
        ciclos(1);
    endtask

    initial begin
        int n;
        // Button held high through reset release must not advance.
        reset = 1'b1; btn_confirma = 1'b1; switch = 9'b000000001;
        ciclos(3);
        reset = 1'b0;
        ciclos(5);
        chk("held_reset_estado", estadoJogo, 3'b000);
        chk("held_reset_linha", regLinha, 0);
        btn_confirma = 1'b0;
        ciclos(2);

        // Full move 3/5/9.
        confirma(9'b000000100);
        chk("move_linha", regLinha, 3);
        chk("move_estado_col", estadoJogo, 3'b001);
        confirma(9'b000010000);
        chk("move_coluna", regColuna, 5);
        chk("move_consulta_req", consulta_req, 1);
        pulso_ok(1'b0);
        chk("move_estado_valor", estadoJogo, 3'b011);
        confirma(9'b100000000);
        chk("move_valor", regValor, 9);
        chk("move_escrita_req", escrita_req, 1);
        @(negedge clk); escrita_ack = 1'b1;
        @(negedge clk); escrita_ack = 1'b0;
        ciclos(1);
        chk("move_fim_estado", estadoJogo, 3'b000);
        chk("move_fim_regs", {regLinha, regColuna, regValor}, 0);

        // Fixed cell: erro for exactly ERRO cycles, then back to row select.
        confirma(9'b000000001);
        confirma(9'b000000010);
        @(negedge clk); consulta_ok = 1'b1; celula_fixa = 1'b1;
        @(negedge clk); consulta_ok = 1'b0; celula_fixa = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (erro) n++;
            @(negedge clk);
        end
        chk("fixa_erro_ciclos", n, 4);
        chk("fixa_estado", estadoJogo, 3'b000);
        chk("fixa_linha", regLinha, 0);

        // Invalid switch pattern: one-cycle erro pulse, nothing else changes.
        @(negedge clk); switch = 9'b000000011; btn_confirma = 1'b1;
        @(negedge clk); btn_confirma = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (erro) n++;
            @(negedge clk);
        end
        chk("inval_erro_ciclos", n, 1);
        chk("inval_estado", estadoJogo, 3'b000);
        chk("inval_linha", regLinha, 0);

        // Confirm and cancel together in S_VALOR: cancel wins.
        confirma(9'b000000010);
        confirma(9'b001000000);
        pulso_ok(1'b0);
        @(negedge clk); switch = 9'b000000001; btn_confirma = 1'b1; btn_cancela = 1'b1;
        @(negedge clk); btn_confirma = 1'b0; btn_cancela = 1'b0;
        ciclos(2);
        chk("prio_estado", estadoJogo, 3'b001);
        chk("prio_coluna", regColuna, 0);
        chk("prio_valor", regValor, 0);
        chk("prio_linha", regLinha, 2);

        // Cancel in S_COLUNA returns to row select.
        cancela();
        chk("canc_col_estado", estadoJogo, 3'b000);

        // Confirm held 10 cycles: exactly one advance.
        @(negedge clk); switch = 9'b000000001; btn_confirma = 1'b1;
        ciclos(10);
        btn_confirma = 1'b0;
        ciclos(2);
        chk("held_estado", estadoJogo, 3'b001);
        chk("held_linha", regLinha, 1);

        // Idle in S_COLUNA.
        ciclos(100);
`ifdef ENTRADA_TIMEOUT_EN
        chk("idle_estado", estadoJogo, 3'b000);
        chk("idle_linha", regLinha, 0);
        confirma(9'b000000001);
`else
        chk("idle_estado", estadoJogo, 3'b001);
        chk("idle_linha", regLinha, 1);
`endif

        // Reset in the middle of the write handshake.
        confirma(9'b000000100);
        pulso_ok(1'b0);
        confirma(9'b000100000);
        chk("rst_pre_escrita_req", escrita_req, 1);
        chk("rst_pre_valor", regValor, 6);
        @(negedge clk); reset = 1'b1; escrita_ack = 1'b1;
        @(negedge clk); reset = 1'b0; escrita_ack = 1'b0;
        chk("rst_escrita_req", escrita_req, 0);
        chk("rst_estado", estadoJogo, 3'b000);
        chk("rst_valor", regValor, 0);

        // Stray acks with nothing outstanding.
        @(negedge clk); escrita_ack = 1'b1; consulta_ok = 1'b1;
        @(negedge clk); escrita_ack = 1'b0; consulta_ok = 1'b0;
        ciclos(2);
        chk("stray_estado", estadoJogo, 3'b000);
        chk("stray_req", {consulta_req, escrita_req}, 0);

        ciclos(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
